// File: rtl/io_port_fifo.sv
// Show-ahead synchronous FIFO; empty/full come only from the registered occupancy count.
module io_port_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/io_port_endpoint.sv
// Peripheral end of one datapath I/O port: outbound FIFO for io writes, inbound FIFO for io reads.
module io_port_endpoint #(
    parameter int WORD_WIDTH = 36,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] io_write_data,
    input  logic                  io_rden,
    output logic [WORD_WIDTH-1:0] io_read_data,
    output logic                  io_in_EF,
    output logic                  io_out_EF,
    output logic [WORD_WIDTH-1:0] ext_out_data,
    output logic                  ext_out_valid,
    input  logic                  ext_out_ready,
    input  logic [WORD_WIDTH-1:0] ext_in_data,
    input  logic                  ext_in_valid,
    output logic                  ext_in_ready,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic                  out_empty, out_full;
    logic                  in_empty, in_full;
    logic [WORD_WIDTH-1:0] in_rdata;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_underflow_q, err_underflow_d;

    io_port_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_out_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (io_wren),
        .wdata (io_write_data),
        .pop   (ext_out_ready),
        .rdata (ext_out_data),
        .empty (out_empty),
        .full  (out_full)
    );

    io_port_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_in_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (ext_in_valid),
        .wdata (ext_in_data),
        .pop   (io_rden),
        .rdata (in_rdata),
        .empty (in_empty),
        .full  (in_full)
    );

    assign io_out_EF     = ~out_full;
    assign ext_out_valid = ~out_empty;
    assign io_in_EF      = ~in_empty;
    assign ext_in_ready  = ~in_full;
    assign io_read_data  = in_empty ? '0 : in_rdata;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

    always_comb begin
        err_overflow_d  = err_overflow_q | (io_wren & out_full);
        err_underflow_d = err_underflow_q | (io_rden & in_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

endmodule

// File: tb/tb_io_port_endpoint.sv
// Self-checking bench: flag vector table, hand sequences, and data scoreboards on both streams.
module tb_io_port_endpoint;

    localparam int W = 36;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_wren = 1'b0;
    logic [W-1:0] io_write_data = '0;
    logic         io_rden = 1'b0;
    logic [W-1:0] io_read_data;
    logic         io_in_EF, io_out_EF;
    logic [W-1:0] ext_out_data;
    logic         ext_out_valid;
    logic         ext_out_ready = 1'b0;
    logic [W-1:0] ext_in_data = '0;
    logic         ext_in_valid = 1'b0;
    logic         ext_in_ready;
    logic         err_overflow, err_underflow;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] out_q[$];
    logic [W-1:0] in_q[$];
    int           out_cnt = 0;
    int           in_cnt  = 0;

    io_port_endpoint #(
        .WORD_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_wren       (io_wren),
        .io_write_data (io_write_data),
        .io_rden       (io_rden),
        .io_read_data  (io_read_data),
        .io_in_EF      (io_in_EF),
        .io_out_EF     (io_out_EF),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: transfers happen at the next rising edge, so compare mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (ext_out_valid && ext_out_ready) begin
                if (out_q.size() == 0) check("out_unexpected_word", ext_out_data, 'x);
                else check("out_data", ext_out_data, out_q.pop_front());
            end
            if (io_rden && io_in_EF) begin
                if (in_q.size() == 0) check("in_unexpected_word", io_read_data, 'x);
                else check("in_data", io_read_data, in_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle; queue expected words for pushes the bench model says are accepted.
    task automatic cycle(input logic wren, input logic [W-1:0] wdata, input logic oready,
                         input logic rden, input logic ivalid, input logic [W-1:0] idata);
        bit opush, opop, ipush, ipop;
        io_wren = wren; io_write_data = wdata; ext_out_ready = oready;
        io_rden = rden; ext_in_valid = ivalid; ext_in_data = idata;
        opush = wren && (out_cnt < D);
        opop  = oready && (out_cnt > 0);
        ipush = ivalid && (in_cnt < D);
        ipop  = rden && (in_cnt > 0);
        if (opush) out_q.push_back(wdata);
        if (ipush) in_q.push_back(idata);
        out_cnt += int'(opush) - int'(opop);
        in_cnt  += int'(ipush) - int'(ipop);
        tick();
        io_wren = 1'b0; ext_out_ready = 1'b0; io_rden = 1'b0; ext_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_q.delete(); in_q.delete();
        out_cnt = 0; in_cnt = 0;
    endtask

    typedef struct {
        logic         wren;
        logic [W-1:0] wdata;
        logic         oready;
        logic         rden;
        logic         ivalid;
        logic [W-1:0] idata;
        logic         e_out_ef, e_out_valid, e_in_ef, e_in_ready, e_ovf, e_udf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //          wren wdata oready rden ivalid idata  outEF oval inEF inrdy ovf udf
        vecs[0]  = '{1, 36'h1, 0, 0, 0, 36'h0,  1, 1, 0, 1, 0, 0};
        vecs[1]  = '{1, 36'h2, 0, 0, 0, 36'h0,  1, 1, 0, 1, 0, 0};
        vecs[2]  = '{1, 36'h3, 0, 0, 0, 36'h0,  1, 1, 0, 1, 0, 0};
        vecs[3]  = '{1, 36'h4, 0, 0, 0, 36'h0,  0, 1, 0, 1, 0, 0};
        vecs[4]  = '{1, 36'h5, 0, 0, 0, 36'h0,  0, 1, 0, 1, 1, 0};
        vecs[5]  = '{0, 36'h0, 1, 0, 0, 36'h0,  1, 1, 0, 1, 1, 0};
        vecs[6]  = '{0, 36'h0, 1, 0, 0, 36'h0,  1, 1, 0, 1, 1, 0};
        vecs[7]  = '{0, 36'h0, 1, 0, 0, 36'h0,  1, 1, 0, 1, 1, 0};
        vecs[8]  = '{0, 36'h0, 1, 0, 0, 36'h0,  1, 0, 0, 1, 1, 0};
        vecs[9]  = '{0, 36'h0, 0, 0, 1, 36'hA,  1, 0, 1, 1, 1, 0};
        vecs[10] = '{0, 36'h0, 0, 1, 1, 36'hB,  1, 0, 1, 1, 1, 0};
        vecs[11] = '{0, 36'h0, 0, 1, 1, 36'hC,  1, 0, 1, 1, 1, 0};
        vecs[12] = '{0, 36'h0, 0, 1, 0, 36'h0,  1, 0, 0, 1, 1, 0};
        vecs[13] = '{0, 36'h0, 0, 1, 0, 36'h0,  1, 0, 0, 1, 1, 1};

        tick(); tick();
        do_reset();

        check("rst_io_out_EF", io_out_EF, 1'b1);
        check("rst_io_in_EF", io_in_EF, 1'b0);
        check("rst_io_read_data", io_read_data, '0);
        check("rst_ext_out_valid", ext_out_valid, 1'b0);
        check("rst_ext_in_ready", ext_in_ready, 1'b1);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_underflow", err_underflow, 1'b0);

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].wren, vecs[i].wdata, vecs[i].oready, vecs[i].rden,
                  vecs[i].ivalid, vecs[i].idata);
            check($sformatf("v%0d_io_out_EF", i), io_out_EF, vecs[i].e_out_ef);
            check($sformatf("v%0d_ext_out_valid", i), ext_out_valid, vecs[i].e_out_valid);
            check($sformatf("v%0d_io_in_EF", i), io_in_EF, vecs[i].e_in_ef);
            check($sformatf("v%0d_ext_in_ready", i), ext_in_ready, vecs[i].e_in_ready);
            check($sformatf("v%0d_err_overflow", i), err_overflow, vecs[i].e_ovf);
            check($sformatf("v%0d_err_underflow", i), err_underflow, vecs[i].e_udf);
            if (!vecs[i].e_in_ef) check($sformatf("v%0d_read_zero", i), io_read_data, '0);
        end
        check("vec_out_drained", out_q.size(), 0);
        check("vec_in_drained", in_q.size(), 0);

        // After the ignored read, the inbound pointers must still line up.
        cycle(0, '0, 0, 0, 1, 36'hD);
        check("after_udf_head", io_read_data, 36'hD);
        cycle(0, '0, 0, 1, 0, '0);
        check("after_udf_empty", io_in_EF, 1'b0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        do_reset();
        cycle(1, 36'h100, 0, 0, 0, '0);
        cycle(1, 36'h101, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 36'(32'h102 + i), 1, 0, 0, '0);
            check($sformatf("wrap%0d_valid", i), ext_out_valid, 1'b1);
            check($sformatf("wrap%0d_out_EF", i), io_out_EF, 1'b1);
        end
        cycle(0, '0, 1, 0, 0, '0);
        check("wrap_one_left", ext_out_valid, 1'b1);
        cycle(0, '0, 1, 0, 0, '0);
        check("wrap_empty", ext_out_valid, 1'b0);
        check("wrap_sb_empty", out_q.size(), 0);
        check("wrap_no_ovf", err_overflow, 1'b0);

        // Full FIFO: write rejected even with a simultaneous pop.
        for (int i = 0; i < 4; i++) cycle(1, 36'(32'h200 + i), 0, 0, 0, '0);
        check("full_out_EF", io_out_EF, 1'b0);
        cycle(1, 36'h204, 1, 0, 0, '0);
        check("full_pop_ovf", err_overflow, 1'b1);
        check("full_pop_out_EF", io_out_EF, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0, '0);
        check("full_drained", ext_out_valid, 1'b0);
        check("full_sb_empty", out_q.size(), 0);

        // Reset with entries queued, including a push attempt in the reset cycle.
        for (int i = 0; i < 3; i++) cycle(1, 36'(32'h300 + i), 0, 0, 0, '0);
        cycle(0, '0, 0, 0, 1, 36'h3FF);
        io_wren = 1'b1; io_write_data = 36'h3AA; ext_in_valid = 1'b1; ext_in_data = 36'h3BB;
        do_reset();
        io_wren = 1'b0; ext_in_valid = 1'b0;
        check("rst_mid_valid", ext_out_valid, 1'b0);
        check("rst_mid_out_EF", io_out_EF, 1'b1);
        check("rst_mid_in_EF", io_in_EF, 1'b0);
        check("rst_mid_ovf", err_overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 1, 1, 0, '0);
            check($sformatf("rst_mid_stale%0d", i), ext_out_valid, 1'b0);
        end
        check("rst_mid_udf", err_underflow, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
